// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
//   Multi-cycle ripple-carry adder/subtractor. WIDTH-bit operands are summed
//   CHUNK bits per clock, with the carry held in a register between chunks.
//   The result appears N = WIDTH/CHUNK cycles after the operands are accepted.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  WIDTH-bit operands
//   cin                   carry-in for addition (ignored when sub=1)
//   sub                   0: s = a + b + cin, 1: s = a - b
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   s                     WIDTH-bit sum/difference, wraps modulo 2^WIDTH
//   cout                  carry out of the MSB (for sub: 1 = no borrow)
//   ovf                   signed overflow
//   busy                  high in RUN or DONE
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;
  logic             accept;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] s_nxt;
  logic             msb_cin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && (state == IDLE);
  assign last      = (idx == IW'(N - 1));

  // Operands are shifted right each RUN cycle so the active chunk always sits
  // in the low CHUNK bits; the result is shifted in from the top, so after N
  // cycles every chunk lands in its own slot s[idx*CHUNK +: CHUNK].
  always_comb begin
    csum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    s_nxt = s >> CHUNK;
    s_nxt[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
    // Carry into the top bit of this chunk, recovered from its sum bit.
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ csum[CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub | cin;
      idx   <= '0;
      s     <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      carry <= csum[CHUNK];
      s     <= s_nxt;
      idx   <= idx + IW'(1);
      if (last) begin
        cout <= csum[CHUNK];
        ovf  <= csum[CHUNK] ^ msb_cin;
      end
    end
  end

endmodule
